// File: rtl/ps2_keys_pkg.sv
// Shared PS/2 set-2 scancode constants and decoder state encoding for the
// bowling-control key decoder.
package ps2_keys_pkg;

    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    // Keyboard housekeeping replies that never belong to a key sequence
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_BAT_OK = 8'hAA;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_RESEND = 8'hFE;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_GOT_E0   = 2'b01,
        ST_GOT_F0   = 2'b10,
        ST_GOT_E0F0 = 2'b11
    } ps2_state_t;

    function automatic logic is_ignored(input logic [7:0] code);
        logic hit;
        case (code)
            SC_ACK, SC_BAT_OK, SC_ECHO, SC_RESEND: hit = 1'b1;
            default:                               hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/ps2_key_decoder.sv
// Turns the raw PS/2 byte stream into registered aim/power key events,
// handling E0/F0 prefixes, typematic repeats and abandoned prefixes.
module ps2_key_decoder
    import ps2_keys_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned TMR_W          = 20,
    parameter bit          AIM_REPEAT     = 1'b1
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic       aim_left,
    output logic       aim_right,
    output logic       power_press,
    output logic       power_release,
    output logic       power_held,
    output logic [7:0] last_key
);

    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 32'd1);
    localparam logic [TMR_W-1:0] TMR_ONE      = {{(TMR_W-1){1'b0}}, 1'b1};

    ps2_state_t       state_r;
    ps2_state_t       state_nxt_s;
    logic [TMR_W-1:0] timer_r;
    logic [TMR_W-1:0] timer_nxt_s;

    logic byte_valid_s;
    logic seq_done_s;
    logic seq_ext_s;
    logic seq_brk_s;

    logic hit_left_s;
    logic hit_right_s;
    logic hit_space_s;

    logic       aim_left_r;
    logic       aim_right_r;
    logic       power_press_r;
    logic       power_release_r;
    logic       power_held_r;
    logic [7:0] last_key_r;
    logic       left_held_r;
    logic       right_held_r;

    logic       aim_left_nxt_s;
    logic       aim_right_nxt_s;
    logic       power_press_nxt_s;
    logic       power_release_nxt_s;
    logic       power_held_nxt_s;
    logic [7:0] last_key_nxt_s;
    logic       left_held_nxt_s;
    logic       right_held_nxt_s;

    assign byte_valid_s = received_data_en & ~is_ignored(received_data);

    // Prefix FSM state and timeout counter
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            timer_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            timer_r <= timer_nxt_s;
        end
    end

    // Next-state logic; a byte on the final position reports a completed sequence
    always_comb begin
        state_nxt_s = state_r;
        timer_nxt_s = timer_r;
        seq_done_s  = 1'b0;
        seq_ext_s   = 1'b0;
        seq_brk_s   = 1'b0;
        if (byte_valid_s) begin
            timer_nxt_s = '0;
            case (state_r)
                ST_IDLE: begin
                    if (received_data == SC_E0) begin
                        state_nxt_s = ST_GOT_E0;
                    end else if (received_data == SC_F0) begin
                        state_nxt_s = ST_GOT_F0;
                    end else begin
                        seq_done_s = 1'b1;
                    end
                end
                ST_GOT_E0: begin
                    if (received_data == SC_F0) begin
                        state_nxt_s = ST_GOT_E0F0;
                    end else if (received_data == SC_E0) begin
                        state_nxt_s = ST_GOT_E0;
                    end else begin
                        seq_done_s  = 1'b1;
                        seq_ext_s   = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_GOT_F0: begin
                    if (received_data == SC_E0) begin
                        state_nxt_s = ST_GOT_E0F0;
                    end else if (received_data == SC_F0) begin
                        state_nxt_s = ST_GOT_F0;
                    end else begin
                        seq_done_s  = 1'b1;
                        seq_brk_s   = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_GOT_E0F0: begin
                    if ((received_data == SC_E0) || (received_data == SC_F0)) begin
                        state_nxt_s = ST_GOT_E0F0;
                    end else begin
                        seq_done_s  = 1'b1;
                        seq_ext_s   = 1'b1;
                        seq_brk_s   = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else if (state_r != ST_IDLE) begin
            // A prefix left dangling too long is dropped without an event
            if (timer_r == TIMEOUT_LAST) begin
                state_nxt_s = ST_IDLE;
                timer_nxt_s = '0;
            end else begin
                timer_nxt_s = timer_r + TMR_ONE;
            end
        end else begin
            timer_nxt_s = '0;
        end
    end

    assign hit_left_s  = seq_done_s & (seq_ext_s ? (received_data == SC_LEFT)
                                                 : (received_data == SC_A));
    assign hit_right_s = seq_done_s & (seq_ext_s ? (received_data == SC_RIGHT)
                                                 : (received_data == SC_D));
    assign hit_space_s = seq_done_s & ~seq_ext_s & (received_data == SC_SPACE);

    // Key mapping, held-flag tracking and pulse generation
    always_comb begin
        aim_left_nxt_s      = 1'b0;
        aim_right_nxt_s     = 1'b0;
        power_press_nxt_s   = 1'b0;
        power_release_nxt_s = 1'b0;
        power_held_nxt_s    = power_held_r;
        left_held_nxt_s     = left_held_r;
        right_held_nxt_s    = right_held_r;
        last_key_nxt_s      = last_key_r;

        if (seq_done_s && !seq_brk_s) begin
            last_key_nxt_s = received_data;
        end else begin
            last_key_nxt_s = last_key_r;
        end

        if (hit_left_s) begin
            if (seq_brk_s) begin
                left_held_nxt_s = 1'b0;
            end else begin
                left_held_nxt_s = 1'b1;
                aim_left_nxt_s  = AIM_REPEAT | ~left_held_r;
            end
        end else begin
            left_held_nxt_s = left_held_r;
        end

        if (hit_right_s) begin
            if (seq_brk_s) begin
                right_held_nxt_s = 1'b0;
            end else begin
                right_held_nxt_s = 1'b1;
                aim_right_nxt_s  = AIM_REPEAT | ~right_held_r;
            end
        end else begin
            right_held_nxt_s = right_held_r;
        end

        // Typematic repeats of SPACE and stray breaks leave power untouched
        if (hit_space_s) begin
            if (seq_brk_s) begin
                if (power_held_r) begin
                    power_release_nxt_s = 1'b1;
                    power_held_nxt_s    = 1'b0;
                end else begin
                    power_held_nxt_s = 1'b0;
                end
            end else begin
                if (!power_held_r) begin
                    power_press_nxt_s = 1'b1;
                    power_held_nxt_s  = 1'b1;
                end else begin
                    power_held_nxt_s = 1'b1;
                end
            end
        end else begin
            power_held_nxt_s = power_held_r;
        end
    end

    // Registered event outputs and held flags
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            aim_left_r      <= 1'b0;
            aim_right_r     <= 1'b0;
            power_press_r   <= 1'b0;
            power_release_r <= 1'b0;
            power_held_r    <= 1'b0;
            last_key_r      <= 8'h00;
            left_held_r     <= 1'b0;
            right_held_r    <= 1'b0;
        end else begin
            aim_left_r      <= aim_left_nxt_s;
            aim_right_r     <= aim_right_nxt_s;
            power_press_r   <= power_press_nxt_s;
            power_release_r <= power_release_nxt_s;
            power_held_r    <= power_held_nxt_s;
            last_key_r      <= last_key_nxt_s;
            left_held_r     <= left_held_nxt_s;
            right_held_r    <= right_held_nxt_s;
        end
    end

    assign aim_left      = aim_left_r;
    assign aim_right     = aim_right_r;
    assign power_press   = power_press_r;
    assign power_release = power_release_r;
    assign power_held    = power_held_r;
    assign last_key      = last_key_r;

endmodule
